daq_sample_capture: RTL and testbench

//  Capture stage downstream of the DAQ read-clock generator (200 MHz clk_i).
//  On each ADC conversion end (busy_i falling), drives rd_en_o to gate the read clock and

---
 rtl/daq_sample_capture.sv | 172 +++++++++++++++++
 tb/tb_daq_sample_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/daq_sample_capture.sv
// Purpose: capture NCH ADC samples per conversion, tag them with the channel index and queue them.
// Latency: read-clock rise in cycle N -> FIFO write at end of N+1 -> m_valid_o in N+2 if the FIFO was empty.
// Backpressure: valid/ready output; when the FIFO is full a sample is dropped unless a pop happens that cycle.

module daq_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_rdy & ~empty;
    // A simultaneous pop frees the slot, so a push while full still succeeds.
    assign do_push = push_vld & (~full | do_pop);
    assign pop_vld = ~empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module daq_sample_capture #(
    parameter int DATA_W     = 16,
    parameter int NCH        = 8,
    parameter int CH_W       = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   en_i,
    input  logic                   busy_i,
    input  logic                   rdclk_i,
    input  logic [DATA_W-1:0]      adc_data_i,
    output logic                   rd_en_o,
    output logic [CH_W+DATA_W-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   frame_done_o,
    output logic                   missed_o,
    output logic                   overflow_o,
    input  logic                   clear_i,
    output logic [15:0]            frame_cnt_o
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   busy_q;
    logic                   rdclk_q;
    logic                   busy_fall;
    logic                   rd_rise;
    logic                   sample_hit;
    logic [CH_W-1:0]        ch_q;
    logic                   cap_vld_q;
    logic [CH_W+DATA_W-1:0] cap_dat_q;
    logic                   rd_en_q;
    logic                   frame_done_q;
    logic                   missed_q;
    logic                   overflow_q;
    logic [15:0]            frame_cnt_q;
    logic                   fifo_full;
    logic                   drop;

    assign busy_fall  = busy_q & ~busy_i;
    assign rd_rise    = rdclk_i & ~rdclk_q;
    assign sample_hit = (state_q == ST_CAPTURE) & rd_rise;
    assign drop       = cap_vld_q & fifo_full & ~m_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (busy_fall && en_i) state_d = ST_CAPTURE;
            ST_CAPTURE: if (rd_rise && ch_q == CH_LAST) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            rdclk_q      <= 1'b0;
            ch_q         <= '0;
            cap_vld_q    <= 1'b0;
            cap_dat_q    <= '0;
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            missed_q     <= 1'b0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_i;
            rdclk_q      <= rdclk_i;
            rd_en_q      <= (state_d == ST_CAPTURE);
            frame_done_q <= (state_d == ST_DONE);
            // A conversion end is only usable in IDLE with capture enabled.
            missed_q     <= busy_fall & ((state_q != ST_IDLE) | ~en_i);
            cap_vld_q    <= sample_hit;
            if (sample_hit) begin
                cap_dat_q <= {ch_q, adc_data_i};
            end
            if (state_q == ST_IDLE && state_d == ST_CAPTURE) begin
                ch_q <= '0;
            end else if (sample_hit) begin
                ch_q <= ch_q + 1'b1;
            end
            if (state_q == ST_DONE) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    daq_fifo #(
        .W     (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_vld  (cap_vld_q),
        .push_dat  (cap_dat_q),
        .pop_rdy   (m_ready_i),
        .pop_vld   (m_valid_o),
        .pop_dat   (m_data_o),
        .full      (fifo_full)
    );

    assign rd_en_o      = rd_en_q;
    assign frame_done_o = frame_done_q;
    assign missed_o     = missed_q;
    assign overflow_o   = overflow_q;
    assign frame_cnt_o  = frame_cnt_q;
endmodule

// File: tb/tb_daq_sample_capture.sv
// Directed bench for daq_sample_capture: stimulus queues expected words, a negedge monitor checks them.
module tb_daq_sample_capture;
    localparam int NCH = 8;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        en_i = 1'b1;
    logic        busy_i = 1'b0;
    logic        rdclk_i = 1'b0;
    logic [15:0] adc_data_i = '0;
    logic        rd_en_o;
    logic [18:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        frame_done_o;
    logic        missed_o;
    logic        overflow_o;
    logic        clear_i = 1'b0;
    logic [15:0] frame_cnt_o;

    daq_sample_capture dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .en_i         (en_i),
        .busy_i       (busy_i),
        .rdclk_i      (rdclk_i),
        .adc_data_i   (adc_data_i),
        .rd_en_o      (rd_en_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .frame_done_o (frame_done_o),
        .missed_o     (missed_o),
        .overflow_o   (overflow_o),
        .clear_i      (clear_i),
        .frame_cnt_o  (frame_cnt_o)
    );

    initial forever #5 clk_i = ~clk_i;

    logic [18:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          missed_seen = 0;
    int          done_seen = 0;
    int          words_popped = 0;
    int          exp_missed = 0;
    int          exp_done = 0;
    logic [15:0] exp_frames = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: count output pulses and score every accepted word.
    initial forever begin
        @(negedge clk_i);
        if (missed_o === 1'b1) missed_seen++;
        if (frame_done_o === 1'b1) done_seen++;
        if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
            words_popped++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", m_data_o);
            end else begin
                check("word", {13'd0, m_data_o}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic busy_fall_seq(input logic rd_en_req);
        busy_i = 1'b1;
        tick();
        busy_i = 1'b0;
        tick();
        check("rd_en_after_fall", {31'd0, rd_en_o}, {31'd0, rd_en_req});
    endtask

    task automatic run_frame(input logic [15:0] base, input bit keep, input int busy_at,
                             input int en_drop_at, input bit pop_on_push);
        busy_fall_seq(1'b1);
        repeat (2) tick();
        for (int c = 0; c < NCH; c++) begin
            adc_data_i = base + 16'(c);
            if (keep) exp_q.push_back({3'(c), base + 16'(c)});
            rdclk_i = 1'b1;
            tick();
            if (pop_on_push) m_ready_i = 1'b1;
            tick();
            if (pop_on_push) m_ready_i = 1'b0;
            if (c == busy_at) begin
                busy_i = 1'b1;
                tick();
                busy_i = 1'b0;
                tick();
                exp_missed++;
            end else begin
                repeat (2) tick();
            end
            tick();
            rdclk_i = 1'b0;
            repeat (5) tick();
            if (c == en_drop_at) en_i = 1'b0;
        end
        repeat (3) tick();
        exp_frames = exp_frames + 16'd1;
        exp_done++;
        check("rd_en_low_after_frame", {31'd0, rd_en_o}, 32'd0);
        check("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, exp_frames});
        check("frame_done_pulses", done_seen, exp_done);
        check("missed_pulses", missed_seen, exp_missed);
    endtask

    task automatic drain();
        m_ready_i = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        check("drain_queue_empty", exp_q.size(), 0);
        check("valid_low_after_drain", {31'd0, m_valid_o}, 32'd0);
    endtask

    initial begin
        int popped_before;
        repeat (3) tick();
        check("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
        check("rst_missed", {31'd0, missed_o}, 32'd0);
        check("rst_overflow", {31'd0, overflow_o}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        reset_n_i = 1'b1;
        repeat (2) tick();

        // Basic frame with a free-running consumer.
        run_frame(16'h1000, 1, -1, -1, 0);
        drain();

        // Conversion end with capture disabled: pulse only, no capture.
        en_i = 1'b0;
        busy_fall_seq(1'b0);
        exp_missed++;
        repeat (3) tick();
        check("disabled_rd_en", {31'd0, rd_en_o}, 32'd0);
        check("disabled_missed", missed_seen, exp_missed);
        check("disabled_no_word", {31'd0, m_valid_o}, 32'd0);
        en_i = 1'b1;

        // Conversion end during sample 3 still yields a full frame.
        run_frame(16'h3000, 1, 3, -1, 0);
        drain();

        // Enable dropped mid-frame, then a conversion end in IDLE with enable low.
        run_frame(16'h4000, 1, -1, 2, 0);
        busy_fall_seq(1'b0);
        exp_missed++;
        repeat (3) tick();
        check("en_drop_missed", missed_seen, exp_missed);
        en_i = 1'b1;
        drain();

        // Overflow: three frames into a 16-entry FIFO with no consumer.
        m_ready_i = 1'b0;
        run_frame(16'h2000, 1, -1, -1, 0);
        run_frame(16'h2100, 1, -1, -1, 0);
        check("no_overflow_at_full", {31'd0, overflow_o}, 32'd0);
        run_frame(16'h2200, 0, -1, -1, 0);
        check("overflow_set", {31'd0, overflow_o}, 32'd1);
        tick();
        check("overflow_sticky", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("overflow_cleared", {31'd0, overflow_o}, 32'd0);
        drain();

        // Full FIFO with a pop on each push cycle: nothing dropped.
        m_ready_i = 1'b0;
        run_frame(16'h5000, 1, -1, -1, 0);
        run_frame(16'h5100, 1, -1, -1, 0);
        run_frame(16'h5200, 1, -1, -1, 1);
        check("no_overflow_push_pop", {31'd0, overflow_o}, 32'd0);
        popped_before = words_popped;
        drain();
        check("occupancy_held_16", words_popped - popped_before, 16);

        // Asynchronous reset in the middle of a capture.
        m_ready_i = 1'b0;
        busy_fall_seq(1'b1);
        repeat (2) tick();
        for (int c = 0; c < 5; c++) begin
            adc_data_i = 16'h6600 + 16'(c);
            rdclk_i = 1'b1;
            repeat (5) tick();
            rdclk_i = 1'b0;
            repeat (5) tick();
        end
        check("rd_en_before_reset", {31'd0, rd_en_o}, 32'd1);
        check("valid_before_reset", {31'd0, m_valid_o}, 32'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_rd_en", {31'd0, rd_en_o}, 32'd0);
        check("async_m_valid", {31'd0, m_valid_o}, 32'd0);
        check("async_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        tick();
        reset_n_i = 1'b1;
        exp_frames = '0;
        m_ready_i = 1'b1;
        repeat (2) tick();
        run_frame(16'h6000, 1, -1, -1, 0);
        drain();

        // Frame counter wrap from a preloaded 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        check("frame_cnt_preload", {16'd0, frame_cnt_o}, 32'h0000FFFF);
        exp_frames = 16'hFFFF;
        run_frame(16'h7000, 1, -1, -1, 0);
        check("frame_cnt_wrapped", {16'd0, frame_cnt_o}, 32'd0);
        drain();

        check("final_missed", missed_seen, exp_missed);
        check("final_done", done_seen, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
